// File: rtl/combo_pkg.sv
// Shared definitions for the 3-bit switch-code lock interface (sender and lock blocks).
`timescale 1ns/1ps
package combo_pkg;
  localparam int SW_W = 3;
  localparam logic [SW_W-1:0] SW_IDLE = 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } sender_state_t;
endpackage

// File: rtl/combo_code_sender_timer.sv
// sender_timer: loadable down-counter that stops at zero; tc_o is high while the count is zero.
`timescale 1ns/1ps
module sender_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);
endmodule

// File: rtl/combo_code_sender.sv
// combo_code_sender: plays a latched combination onto sw, then resolves the lock response.
// Optional replay-once-on-timeout is compiled in with `define COMBO_SENDER_RETRY_EN.
`timescale 1ns/1ps
module combo_code_sender
  import combo_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int HOLD    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SW_W*DIGITS-1:0] code_in,
  input  logic                   locked,
  input  logic                   alarm,
  output logic [SW_W-1:0]        sw,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output sender_state_t          dbg_state
);
  // Handshake: start is a one-cycle request honoured only in IDLE; each accepted
  // start produces exactly one done pulse, with pass valid from that cycle on.
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [3:0] HOLD_LD = 4'(HOLD - 1);
  localparam logic [7:0] TO_LD   = 8'(TIMEOUT);

  sender_state_t            state_q, state_d;
  logic [SW_W*DIGITS-1:0]   code_q, code_d;
  logic [IDX_W-1:0]         idx_q, idx_d, next_idx;
  logic [SW_W-1:0]          sw_q, sw_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     pass_q, pass_d;
  logic                     hold_load, hold_en, hold_tc;
  logic                     to_load, to_en, to_tc;
`ifdef COMBO_SENDER_RETRY_EN
  logic                     retry_q, retry_d;
`endif

  assign next_idx = idx_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    idx_d     = idx_q;
    sw_d      = sw_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    hold_load = 1'b0;
    hold_en   = 1'b0;
    to_load   = 1'b0;
    to_en     = 1'b0;
`ifdef COMBO_SENDER_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      IDLE: begin
        sw_d   = SW_IDLE;
        busy_d = 1'b0;
`ifdef COMBO_SENDER_RETRY_EN
        retry_d = 1'b0;
`endif
        if (start) begin
          code_d    = code_in;
          idx_d     = '0;
          sw_d      = code_in[SW_W-1:0];
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          hold_load = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        hold_en = 1'b1;
        if (hold_tc) begin
          if (idx_q == LAST_IDX) begin
            sw_d    = SW_IDLE;
            to_load = 1'b1;
            state_d = WAIT;
          end else begin
            idx_d     = next_idx;
            sw_d      = code_q[next_idx*SW_W +: SW_W];
            hold_load = 1'b1;
          end
        end
      end
      WAIT: begin
        to_en = 1'b1;
        // alarm outranks a simultaneous unlock
        if (alarm) begin
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (!locked) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (to_tc) begin
`ifdef COMBO_SENDER_RETRY_EN
          if (!retry_q) begin
            retry_d   = 1'b1;
            idx_d     = '0;
            sw_d      = code_q[SW_W-1:0];
            hold_load = 1'b1;
            state_d   = SEND;
          end else begin
            pass_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
`else
          pass_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`endif
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      idx_q   <= '0;
      sw_q    <= SW_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef COMBO_SENDER_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_q <= 1'b0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  sender_timer #(.W(4)) u_hold_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (hold_load),
    .load_val_i (HOLD_LD),
    .en_i       (hold_en),
    .tc_o       (hold_tc)
  );

  sender_timer #(.W(8)) u_wait_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (to_load),
    .load_val_i (TO_LD),
    .en_i       (to_en),
    .tc_o       (to_tc)
  );

  assign sw        = sw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_combo_code_sender.sv
// Directed bench for combo_code_sender: cycle table for the basic unlock, hand sequences for the rest.
`timescale 1ns/1ps
module tb_combo_code_sender;
  import combo_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [11:0]   code_in;
  logic          locked;
  logic          alarm;
  logic [2:0]    sw1, sw3;
  logic          busy1, busy3, done1, done3, pass1, pass3;
  sender_state_t st1, st3;

  int checks = 0;
  int errors = 0;

  combo_code_sender #(.DIGITS(4), .HOLD(1), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .code_in(code_in),
    .locked(locked), .alarm(alarm), .sw(sw1), .busy(busy1),
    .done(done1), .pass(pass1), .dbg_state(st1)
  );

  combo_code_sender #(.DIGITS(4), .HOLD(3), .TIMEOUT(16)) dut3 (
    .clk(clk), .reset(reset), .start(start), .code_in(code_in),
    .locked(locked), .alarm(alarm), .sw(sw3), .busy(busy3),
    .done(done3), .pass(pass3), .dbg_state(st3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       locked;
    logic       alarm;
    logic [2:0] exp_sw;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one edge and settle just after it; inputs are driven and outputs read here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] code);
    start   = 1'b1;
    code_in = code;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy3 || st1 != IDLE || st3 != IDLE) && n < 200) begin
      step();
      n++;
    end
    chk("wait_idle_bound", 32'(n < 200), 32'd1);
  endtask

  logic [11:0] code_a = {3'd4, 3'd3, 3'd2, 3'd1};
  logic [11:0] code_b = {3'd2, 3'd7, 3'd6, 3'd5};

  initial begin
    int ndone;
    reset   = 1'b1;
    start   = 1'b0;
    code_in = '0;
    locked  = 1'b1;
    alarm   = 1'b0;
    step();
    step();
    chk("rst_sw", 32'(sw1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_pass", 32'(pass1), 32'd0);
    chk("rst_state", 32'(st1), 32'(IDLE));
    reset = 1'b0;
    step();

    // Basic unlock, HOLD=1: digits 1..4, lock opens at WAIT cycle 2, done at t0+8.
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    for (int r = 0; r < 11; r++) begin
      chk($sformatf("tbl%0d_sw", r), 32'(sw1), 32'(tbl[r].exp_sw));
      chk($sformatf("tbl%0d_busy", r), 32'(busy1), 32'(tbl[r].exp_busy));
      chk($sformatf("tbl%0d_done", r), 32'(done1), 32'(tbl[r].exp_done));
      chk($sformatf("tbl%0d_pass", r), 32'(pass1), 32'(tbl[r].exp_pass));
      start   = tbl[r].start;
      code_in = code_a;
      locked  = tbl[r].locked;
      alarm   = tbl[r].alarm;
      step();
    end
    start = 1'b0;
    wait_idle();

    // HOLD=3: each digit held 3 cycles, WAIT entered at t0+13.
    do_start(code_a);
    for (int k = 0; k < 4; k++) begin
      for (int h = 0; h < 3; h++) begin
        chk($sformatf("h3_d%0d_c%0d_sw", k, h), 32'(sw3), 32'(k + 1));
        step();
      end
    end
    chk("h3_wait_state", 32'(st3), 32'(WAIT));
    chk("h3_wait_sw", 32'(sw3), 32'd0);
    locked = 1'b0;
    step();
    chk("h3_done", 32'(done3), 32'd1);
    chk("h3_pass", 32'(pass3), 32'd1);
    locked = 1'b1;
    wait_idle();

    // Alarm with simultaneous unlock at WAIT cycle 0: alarm wins.
    do_start(code_a);
    for (int i = 0; i < 4; i++) step();
    chk("alm_state", 32'(st1), 32'(WAIT));
    alarm  = 1'b1;
    locked = 1'b0;
    step();
    chk("alm_done", 32'(done1), 32'd1);
    chk("alm_pass", 32'(pass1), 32'd0);
    alarm  = 1'b0;
    locked = 1'b1;
    step();
    chk("alm_done_once", 32'(done1), 32'd0);
    wait_idle();

    // No response: done TIMEOUT+1 cycles after WAIT entry.
    do_start(code_a);
    for (int i = 0; i < 4; i++) step();
    chk("to_entry", 32'(st1), 32'(WAIT));
    ndone = 0;
    for (int i = 0; i < 17; i++) begin
      if (done1) ndone++;
      step();
    end
    chk("to_no_early_done", 32'(ndone), 32'd0);
`ifdef COMBO_SENDER_RETRY_EN
    chk("to_replay_sw0", 32'(sw1), 32'd1);
    chk("to_replay_busy", 32'(busy1), 32'd1);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("to_replay_sw%0d", k), 32'(sw1), 32'(k + 1));
    end
    for (int i = 0; i < 18; i++) step();
`endif
    chk("to_done", 32'(done1), 32'd1);
    chk("to_pass", 32'(pass1), 32'd0);
    wait_idle();

    // Reset during digit 2 aborts, then a fresh start sends from digit 0.
    do_start(code_a);
    step();
    step();
    chk("rstmid_pre_sw", 32'(sw1), 32'd3);
    reset = 1'b1;
    #1;
    chk("rstmid_sw", 32'(sw1), 32'd0);
    chk("rstmid_busy", 32'(busy1), 32'd0);
    step();
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done1) ndone++;
      step();
    end
    chk("rstmid_no_done", 32'(ndone), 32'd0);
    do_start(code_b);
    chk("fresh_sw0", 32'(sw1), 32'd5);
    step();
    chk("fresh_sw1", 32'(sw1), 32'd6);
    step();
    chk("fresh_sw2", 32'(sw1), 32'd7);
    step();
    chk("fresh_sw3", 32'(sw1), 32'd2);
    step();
    chk("fresh_wait_sw", 32'(sw1), 32'd0);
    locked = 1'b0;
    step();
    locked = 1'b1;
    chk("fresh_done", 32'(done1), 32'd1);
    wait_idle();

    // start held and code_in changed while busy: original sequence, single done.
    do_start(code_a);
    ndone = 0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("busy_start_c%0d_sw", c), 32'(sw1), (c <= 4) ? 32'(c) : 32'd0);
      if (done1) ndone++;
      start   = 1'b1;
      code_in = 12'hFFF;
      locked  = (c == 5) ? 1'b0 : 1'b1;
      step();
    end
    start  = 1'b0;
    locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (done1) ndone++;
      step();
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);
    chk("busy_start_pass", 32'(pass1), 32'd1);
    chk("busy_start_idle", 32'(st1), 32'(IDLE));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
